lpddr5_bank_timing_tracker: RTL and testbench

- Per-bank state and timing tracker for the LPDDR5 controller, placed between the command scheduler and the PHY command encoder.
- Observes every issued DRAM command and maintains, per bank, the state, the open row and the timing counters for tRCD/tRAS/tRC/tRP/tWR, plus the global tRFC/tREFI state.
- Publishes per-bank legality vectors and a refresh request. The scheduler must only issue commands these vectors mark legal.
- Parametrised over bank count, row width and all timing values.

---
 rtl/lpddr5_params.sv | 29 ++
 rtl/lpddr5_bank_fsm.sv | 97 +++++++++
 rtl/lpddr5_bank_timing_tracker.sv | 167 ++++++++++++++++
 tb/tb_lpddr5_bank_timing_tracker.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr5_params.sv
// Shared LPDDR5 controller types: command and bank-state encodings,
// default widths and the refresh debt ceiling.
package lpddr5_params;

   localparam int DEF_BANK_NUM  = 8;
   localparam int DEF_CNT_WIDTH = 8;
   localparam int BANK_IDX_W    = $clog2(DEF_BANK_NUM);
   localparam int REF_DEBT_MAX  = 8;

   typedef logic [DEF_CNT_WIDTH-1:0] bank_timer_t;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } dram_cmd_t;

   typedef enum logic [2:0] {
      BS_IDLE        = 3'd0,
      BS_ACTIVATING  = 3'd1,
      BS_ACTIVE      = 3'd2,
      BS_PRECHARGING = 3'd3,
      BS_REFRESHING  = 3'd4
   } bank_state_t;

endpackage

// File: rtl/lpddr5_bank_fsm.sv
// One LPDDR5 bank: state, open row and rcd/ras/rc/rp/wr timers.
// Ports: do_* command strobes (already legal), rfc_done from top,
// row for ACT; act_ok/rdwr_ok/pre_ok/idle legality, open/open_row.
module lpddr5_bank_fsm
   import lpddr5_params::*;
#(
   parameter int ROW_WIDTH = 16,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int T_RCD     = 4,
   parameter int T_RAS     = 10,
   parameter int T_RC      = 14,
   parameter int T_RP      = 4,
   parameter int T_WR      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 do_act,
   input  logic                 do_wr,
   input  logic                 do_pre,
   input  logic                 do_ref,
   input  logic                 rfc_done,
   input  logic [ROW_WIDTH-1:0] row,
   output logic                 act_ok,
   output logic                 rdwr_ok,
   output logic                 pre_ok,
   output logic                 idle,
   output logic                 open,
   output logic [ROW_WIDTH-1:0] open_row
);

   localparam int CW = CNT_WIDTH;

   bank_state_t   state;
   logic [CW-1:0] rcd, ras, rc, rp, wr;

   function automatic logic [CW-1:0] dec(
      input logic [CW-1:0] t
   );
      return (t == '0) ? t : t - CW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BS_IDLE;
         rcd      <= '0;
         ras      <= '0;
         rc       <= '0;
         rp       <= '0;
         wr       <= '0;
         open     <= 1'b0;
         open_row <= '0;
      end else begin
         rcd <= dec(rcd);
         ras <= dec(ras);
         rc  <= dec(rc);
         rp  <= dec(rp);
         wr  <= dec(wr);
         // leave the waiting state on the edge where the
         // timer reaches 0, so the new state and the zero
         // timer become visible in the same cycle
         case (state)
            BS_ACTIVATING:
               if (rcd <= CW'(1)) state <= BS_ACTIVE;
            BS_PRECHARGING:
               if (rp <= CW'(1)) state <= BS_IDLE;
            BS_REFRESHING:
               if (rfc_done) state <= BS_IDLE;
            default: ;
         endcase
         if (do_act) begin
            state    <= (T_RCD <= 1) ? BS_ACTIVE
                                     : BS_ACTIVATING;
            rcd      <= CW'(T_RCD - 1);
            ras      <= CW'(T_RAS - 1);
            rc       <= CW'(T_RC - 1);
            open     <= 1'b1;
            open_row <= row;
         end
         if (do_wr) wr <= CW'(T_WR - 1);
         if (do_pre) begin
            state <= (T_RP <= 1) ? BS_IDLE
                                 : BS_PRECHARGING;
            rp    <= CW'(T_RP - 1);
            open  <= 1'b0;
         end
         if (do_ref) state <= BS_REFRESHING;
      end
   end

   assign idle    = (state == BS_IDLE) && (rp == '0);
   assign act_ok  = idle && (rc == '0);
   assign rdwr_ok = (state == BS_ACTIVE);
   assign pre_ok  = ((state == BS_ACTIVATING) ||
                     (state == BS_ACTIVE)) &&
                    (ras == '0) && (wr == '0);

endmodule

// File: rtl/lpddr5_bank_timing_tracker.sv
// Per-bank LPDDR5 state/timing tracker with refresh scheduling.
// Ports: cmd_* observed command in; act_ok/rdwr_ok/pre_ok/ref_ok
// legality, bank_open/open_row, refresh_req, cmd_err out.
// Option LPDDR5_REF_POSTPONE_EN: refresh debt counter + refresh_urgent.
module lpddr5_bank_timing_tracker
   import lpddr5_params::*;
#(
   parameter int BANK_NUM  = DEF_BANK_NUM,
   parameter int ROW_WIDTH = 16,
   parameter int T_RCD     = 4,
   parameter int T_RAS     = 10,
   parameter int T_RC      = 14,
   parameter int T_RP      = 4,
   parameter int T_WR      = 4,
   parameter int T_RFC     = 20,
   parameter int T_REFI    = 100,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   input  dram_cmd_t                     cmd,
   input  logic [$clog2(BANK_NUM)-1:0]   cmd_bank,
   input  logic [ROW_WIDTH-1:0]          cmd_row,
   output logic [BANK_NUM-1:0]           act_ok,
   output logic [BANK_NUM-1:0]           rdwr_ok,
   output logic [BANK_NUM-1:0]           pre_ok,
   output logic                          ref_ok,
   output logic [BANK_NUM-1:0]           bank_open,
   output logic [BANK_NUM*ROW_WIDTH-1:0] open_row,
   output logic                          refresh_req,
`ifdef LPDDR5_REF_POSTPONE_EN
   output logic                          refresh_urgent,
`endif
   output logic                          cmd_err
);

   localparam int BIW    = $clog2(BANK_NUM);
   localparam int CW     = CNT_WIDTH;
   localparam int REFI_W = $clog2(T_REFI + 1);

   logic                is_nop, is_act, is_rd;
   logic                is_wr, is_pre, is_ref;
   logic                cmd_legal;
   logic                go_act, go_wr, go_pre, do_ref;
   logic [BANK_NUM-1:0] idle;
   logic [CW-1:0]       rfc;
   logic                rfc_done;
   logic [REFI_W-1:0]   refi;
   logic                refi_wrap;

   always_comb begin
      is_nop = 1'b0;
      is_act = 1'b0;
      is_rd  = 1'b0;
      is_wr  = 1'b0;
      is_pre = 1'b0;
      is_ref = 1'b0;
      case (cmd)
         CMD_NOP: is_nop = 1'b1;
         CMD_ACT: is_act = 1'b1;
         CMD_RD:  is_rd  = 1'b1;
         CMD_WR:  is_wr  = 1'b1;
         CMD_PRE: is_pre = 1'b1;
         CMD_REF: is_ref = 1'b1;
         default: ;
      endcase
   end

   // undefined encodings leave every is_* low, so they
   // fall out as illegal
   assign cmd_legal =
      is_nop
      | (is_act & act_ok[cmd_bank])
      | ((is_rd | is_wr) & rdwr_ok[cmd_bank])
      | (is_pre & pre_ok[cmd_bank])
      | (is_ref & ref_ok);

   assign go_act = cmd_valid & is_act & act_ok[cmd_bank];
   assign go_wr  = cmd_valid & is_wr & rdwr_ok[cmd_bank];
   assign go_pre = cmd_valid & is_pre & pre_ok[cmd_bank];
   assign do_ref = cmd_valid & is_ref & ref_ok;

   assign ref_ok   = &idle;
   assign rfc_done = (rfc <= CW'(1));

   for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      logic sel;
      assign sel = (cmd_bank == BIW'(b));

      lpddr5_bank_fsm #(
         .ROW_WIDTH (ROW_WIDTH),
         .CNT_WIDTH (CNT_WIDTH),
         .T_RCD     (T_RCD),
         .T_RAS     (T_RAS),
         .T_RC      (T_RC),
         .T_RP      (T_RP),
         .T_WR      (T_WR)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .do_act   (go_act & sel),
         .do_wr    (go_wr & sel),
         .do_pre   (go_pre & sel),
         .do_ref   (do_ref),
         .rfc_done (rfc_done),
         .row      (cmd_row),
         .act_ok   (act_ok[b]),
         .rdwr_ok  (rdwr_ok[b]),
         .pre_ok   (pre_ok[b]),
         .idle     (idle[b]),
         .open     (bank_open[b]),
         .open_row (open_row[b*ROW_WIDTH +: ROW_WIDTH])
      );
   end

   assign refi_wrap = (refi == REFI_W'(T_REFI - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rfc     <= '0;
         refi    <= '0;
         cmd_err <= 1'b0;
      end else begin
         if (do_ref)
            rfc <= CW'(T_RFC - 1);
         else if (rfc != '0)
            rfc <= rfc - CW'(1);
         refi    <= refi_wrap ? '0 : refi + REFI_W'(1);
         cmd_err <= cmd_valid & ~cmd_legal;
      end
   end

`ifdef LPDDR5_REF_POSTPONE_EN
   logic [3:0] debt;

   always_ff @(posedge clk) begin
      if (rst) begin
         debt <= '0;
      end else begin
         // wrap and REF together cancel out
         case ({refi_wrap, do_ref})
            2'b10:
               if (debt != 4'(REF_DEBT_MAX))
                  debt <= debt + 4'd1;
            2'b01:
               if (debt != '0)
                  debt <= debt - 4'd1;
            default: ;
         endcase
      end
   end

   assign refresh_req    = (debt != '0);
   assign refresh_urgent = (debt >= 4'(REF_DEBT_MAX));
`else
   always_ff @(posedge clk) begin
      if (rst)
         refresh_req <= 1'b0;
      else if (refi_wrap)
         refresh_req <= 1'b1;
      else if (do_ref)
         refresh_req <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_lpddr5_bank_timing_tracker.sv
// Bench for lpddr5_bank_timing_tracker: directed scenarios plus
// random commands against a cycle-time based reference model.
module tb_lpddr5_bank_timing_tracker;
   import lpddr5_params::*;

   localparam int B      = 8;
   localparam int RW     = 16;
   localparam int T_RCD  = 4;
   localparam int T_RAS  = 10;
   localparam int T_RC   = 14;
   localparam int T_RP   = 4;
   localparam int T_WR   = 4;
   localparam int T_RFC  = 20;
   localparam int T_REFI = 100;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   dram_cmd_t       cmd;
   logic [2:0]      cmd_bank;
   logic [RW-1:0]   cmd_row;
   logic [B-1:0]    act_ok, rdwr_ok, pre_ok, bank_open;
   logic            ref_ok, refresh_req, cmd_err;
   logic [B*RW-1:0] open_row;
`ifdef LPDDR5_REF_POSTPONE_EN
   logic            refresh_urgent;
`endif

   always #5 clk = ~clk;

   lpddr5_bank_timing_tracker #(
      .BANK_NUM  (B),
      .ROW_WIDTH (RW),
      .T_RCD     (T_RCD),
      .T_RAS     (T_RAS),
      .T_RC      (T_RC),
      .T_RP      (T_RP),
      .T_WR      (T_WR),
      .T_RFC     (T_RFC),
      .T_REFI    (T_REFI),
      .CNT_WIDTH (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .cmd_bank       (cmd_bank),
      .cmd_row        (cmd_row),
      .act_ok         (act_ok),
      .rdwr_ok        (rdwr_ok),
      .pre_ok         (pre_ok),
      .ref_ok         (ref_ok),
      .bank_open      (bank_open),
      .open_row       (open_row),
      .refresh_req    (refresh_req),
`ifdef LPDDR5_REF_POSTPONE_EN
      .refresh_urgent (refresh_urgent),
`endif
      .cmd_err        (cmd_err)
   );

   int errors = 0;
   int checks = 0;

   // model: absolute cycle of the last ACT/PRE/WR per bank and
   // of the last REF; legality is "enough cycles have passed"
   longint        now;
   longint        t_act[B];
   longint        t_pre[B];
   longint        t_wr[B];
   longint        t_ref;
   bit            m_open[B];
   logic [RW-1:0] m_row[B];
   bit            m_req;
   int            m_debt;
   bit            m_err;

   task automatic check(
      input string        tag,
      input logic [127:0] got,
      input logic [127:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h",
                  tag, now, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int b = 0; b < B; b++) begin
         t_act[b]  = -1000;
         t_pre[b]  = -1000;
         t_wr[b]   = -1000;
         m_open[b] = 1'b0;
         m_row[b]  = '0;
      end
      t_ref  = -1000;
      m_req  = 1'b0;
      m_debt = 0;
      m_err  = 1'b0;
      now    = 0;
   endtask

   function automatic bit m_act_ok(int b);
      return !m_open[b] && now >= t_pre[b] + T_RP &&
             now >= t_act[b] + T_RC &&
             now >= t_ref + T_RFC;
   endfunction

   function automatic bit m_rdwr_ok(int b);
      return m_open[b] && now >= t_act[b] + T_RCD;
   endfunction

   function automatic bit m_pre_ok(int b);
      return m_open[b] && now >= t_act[b] + T_RAS &&
             now >= t_wr[b] + T_WR;
   endfunction

   function automatic bit m_ref_ok();
      bit ok = (now >= t_ref + T_RFC);
      for (int b = 0; b < B; b++)
         if (m_open[b] || now < t_pre[b] + T_RP) ok = 1'b0;
      return ok;
   endfunction

   function automatic bit m_legal(int c, int b);
      case (c)
         0:       return 1'b1;
         1:       return m_act_ok(b);
         2, 3:    return m_rdwr_ok(b);
         4:       return m_pre_ok(b);
         5:       return m_ref_ok();
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_req_exp();
`ifdef LPDDR5_REF_POSTPONE_EN
      return m_debt != 0;
`else
      return m_req;
`endif
   endfunction

   task automatic m_apply(
      input bit r, input bit v, input int c,
      input int b, input logic [RW-1:0] row
   );
      bit legal, wrap, did_ref;
      if (r) begin
         m_reset();
         return;
      end
      legal   = m_legal(c, b);
      wrap    = (now % T_REFI) == T_REFI - 1;
      did_ref = v && legal && c == 5;
      if (v && legal) begin
         case (c)
            1: begin
               t_act[b]  = now;
               m_open[b] = 1'b1;
               m_row[b]  = row;
            end
            3: t_wr[b] = now;
            4: begin
               t_pre[b]  = now;
               m_open[b] = 1'b0;
            end
            5: t_ref = now;
            default: ;
         endcase
      end
      m_err = v && !legal;
      if (wrap) m_req = 1'b1;
      else if (did_ref) m_req = 1'b0;
      if (wrap && !did_ref && m_debt < REF_DEBT_MAX)
         m_debt++;
      else if (did_ref && !wrap && m_debt > 0)
         m_debt--;
      now++;
   endtask

   task automatic check_all();
      logic [B-1:0]    ea, er, ep, eo;
      logic [B*RW-1:0] erow;
      for (int b = 0; b < B; b++) begin
         ea[b] = m_act_ok(b);
         er[b] = m_rdwr_ok(b);
         ep[b] = m_pre_ok(b);
         eo[b] = m_open[b];
         erow[b*RW +: RW] = m_row[b];
      end
      check("act_ok", act_ok, ea);
      check("rdwr_ok", rdwr_ok, er);
      check("pre_ok", pre_ok, ep);
      check("ref_ok", ref_ok, m_ref_ok());
      check("bank_open", bank_open, eo);
      check("open_row", open_row, erow);
      check("refresh_req", refresh_req, m_req_exp());
      check("cmd_err", cmd_err, m_err);
`ifdef LPDDR5_REF_POSTPONE_EN
      check("refresh_urgent", refresh_urgent,
            m_debt >= REF_DEBT_MAX);
`endif
   endtask

   // one clock cycle: check, drive at negedge, model at posedge
   task automatic cyc(
      input bit r, input bit v, input int c,
      input int b, input logic [RW-1:0] row
   );
      logic [2:0] c3;
      check_all();
      c3        = c[2:0];
      rst       = r;
      cmd_valid = v;
      cmd       = dram_cmd_t'(c3);
      cmd_bank  = b[2:0];
      cmd_row   = row;
      @(posedge clk);
      m_apply(r, v, c, b, row);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
      cmd_bank  = '0;
      cmd_row   = '0;
      @(posedge clk);
      m_reset();
      @(negedge clk);

      // ACT b2 at t=10, rdwr legal from t=14
      idle(10);
      cyc(0, 1, 1, 2, 16'h1234);
      check("tp1_open", bank_open[2], 1'b1);
      check("tp1_row", open_row[2*RW +: RW], 16'h1234);
      idle(2);
      check("tp1_rdwr_t13", rdwr_ok[2], 1'b0);
      idle(1);
      check("tp1_rdwr_t14", rdwr_ok[2], 1'b1);

      // early PRE rejected, next one accepted
      cyc(1, 0, 0, 0, '0);
      cyc(0, 1, 1, 0, 16'h00aa);
      idle(8);
      cyc(0, 1, 4, 0, '0);
      check("tp2_err", cmd_err, 1'b1);
      check("tp2_still_open", rdwr_ok[0], 1'b1);
      cyc(0, 1, 4, 0, '0);
      check("tp2_err_clr", cmd_err, 1'b0);
      idle(2);
      check("tp2_act_t13", act_ok[0], 1'b0);
      idle(1);
      check("tp2_act_t14", act_ok[0], 1'b1);

      // WR at t=20 holds off PRE until t=24
      cyc(1, 0, 0, 0, '0);
      cyc(0, 1, 1, 1, 16'h0beef);
      idle(19);
      cyc(0, 1, 3, 1, '0);
      idle(2);
      check("tp3_pre_t23", pre_ok[1], 1'b0);
      idle(1);
      check("tp3_pre_t24", pre_ok[1], 1'b1);

      // refresh interval and REF
      cyc(1, 0, 0, 0, '0);
      idle(99);
      check("tp4_req_t99", refresh_req, 1'b0);
      idle(1);
      check("tp4_req_t100", refresh_req, 1'b1);
      check("tp4_ref_ok", ref_ok, 1'b1);
      cyc(0, 1, 5, 0, '0);
      check("tp4_req_clr", refresh_req, 1'b0);
      check("tp4_act_blk", act_ok, 8'h00);
      idle(18);
      check("tp4_act_t119", act_ok, 8'h00);
      idle(1);
      check("tp4_act_t120", act_ok, 8'hff);
      cyc(0, 1, 6, 0, '0);
      check("tp4_undef_cmd", cmd_err, 1'b1);

`ifdef LPDDR5_REF_POSTPONE_EN
      cyc(1, 0, 0, 0, '0);
      idle(800);
      check("tp5_urgent", refresh_urgent, 1'b1);
      idle(5);
      cyc(0, 1, 5, 0, '0);
      check("tp5_urgent_clr", refresh_urgent, 1'b0);
      check("tp5_req", refresh_req, 1'b1);
`endif

      // reset mid-operation, with a command during reset
      cyc(1, 0, 0, 0, '0);
      idle(3);
      cyc(0, 1, 1, 3, 16'h7777);
      idle(1);
      cyc(1, 1, 1, 4, 16'h1111);
      check("tp6_act", act_ok, 8'hff);
      check("tp6_open", bank_open, 8'h00);
      check("tp6_row", open_row, '0);
      check("tp6_req", refresh_req, 1'b0);
      check("tp6_err", cmd_err, 1'b0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         int c, b;
         bit v, r;
         logic [RW-1:0] row;
         c   = $urandom_range(0, 7);
         b   = $urandom_range(0, B - 1);
         v   = ($urandom_range(0, 4) != 0);
         row = RW'($urandom);
         if (v && $urandom_range(0, 9) < 7) begin
            for (int k = 0; k < 16 && !m_legal(c, b); k++) begin
               c = $urandom_range(1, 5);
               b = $urandom_range(0, B - 1);
            end
         end
         if (m_req_exp() && m_ref_ok() &&
             $urandom_range(0, 1) == 1) begin
            v = 1'b1;
            c = 5;
         end
         r = ($urandom_range(0, 599) == 0);
         cyc(r, v, c, b, row);
      end
      check_all();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
